// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
//
// Purpose: state encoding, NOP constant and default geometry shared by the
// fetch stage, the instruction memory model and the top level.
package fetch_pkg;

  // Default word-address width and first fetch address after reset.
  localparam int unsigned DEFAULT_ADDR_WIDTH = 16;
  localparam int unsigned DEFAULT_RESET_PC   = 0;

  // All-zero word decodes as NOP downstream.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Fetch FSM states.
  //   ST_IDLE    : out of reset, no request yet
  //   ST_FETCH   : request outstanding on the correct path
  //   ST_HOLD    : instruction register valid, waiting for consumption
  //   ST_DISCARD : request outstanding on a wrong path, data will be dropped
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_HOLD    = 2'd2,
    ST_DISCARD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - program counter, imem request/ack and instruction register
//
// Purpose: owns the PC, issues one instruction-memory request at a time,
// holds each fetched word until downstream consumes it, and applies branch
// redirects, discarding any wrong-path fetch already in flight.
//
// Ports:
//   clock        in   rising-edge clock
//   resetN       in   asynchronous active-low reset
//   imemReq      out  fetch request (decoded from state register)
//   imemAddr     out  fetch address, stable while a request is outstanding
//   imemAck      in   memory response, imemData valid in the same cycle
//   imemData     in   fetched 32-bit word
//   branch       in   single-cycle redirect request
//   branchTarget in   redirect address, sampled with branch
//   stall        in   downstream not ready
//   instruction  out  instruction register
//   instrValid   out  instruction holds a valid, unconsumed word
//   pc           out  address of the word in instruction
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC),
  parameter logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(1)
) (
  input  logic                  clock,
  input  logic                  resetN,
  output logic                  imemReq,
  output logic [ADDR_WIDTH-1:0] imemAddr,
  input  logic                  imemAck,
  input  logic [31:0]           imemData,
  input  logic                  branch,
  input  logic [ADDR_WIDTH-1:0] branchTarget,
  input  logic                  stall,
  output logic [31:0]           instruction,
  output logic                  instrValid,
  output logic [ADDR_WIDTH-1:0] pc
);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDR_WIDTH-1:0] redirect_addr_q, redirect_addr_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]           instr_q, instr_d;

  // State register.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      fetch_addr_q    <= RESET_PC;
      redirect_addr_q <= RESET_PC;
      pc_q            <= RESET_PC;
      instr_q         <= NOP_INSTR;
    end else begin
      fetch_addr_q    <= fetch_addr_d;
      redirect_addr_q <= redirect_addr_d;
      pc_q            <= pc_d;
      instr_q         <= instr_d;
    end
  end

  // Next-state and datapath update. Branch is evaluated first in every
  // state because it overrides consumption and ack handling.
  always_comb begin
    state_d         = state_q;
    fetch_addr_d    = fetch_addr_q;
    redirect_addr_d = redirect_addr_q;
    pc_d            = pc_q;
    instr_d         = instr_q;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
        if (branch) begin
          fetch_addr_d = branchTarget;
        end
      end

      ST_FETCH: begin
        if (imemAck) begin
          if (branch) begin
            // Acked word is on the old path: drop it and re-request at the
            // target straight away, the memory is already free.
            fetch_addr_d = branchTarget;
          end else begin
            instr_d      = imemData;
            pc_d         = fetch_addr_q;
            fetch_addr_d = fetch_addr_q + PC_STEP;
            state_d      = ST_HOLD;
          end
        end else if (branch) begin
          // Transaction cannot be aborted; park the target until the ack.
          redirect_addr_d = branchTarget;
          state_d         = ST_DISCARD;
        end
      end

      ST_HOLD: begin
        if (branch) begin
          // Held word is dropped even if consumed this cycle.
          fetch_addr_d = branchTarget;
          state_d      = ST_FETCH;
        end else if (!stall) begin
          state_d = ST_FETCH;
        end
      end

      ST_DISCARD: begin
        if (imemAck) begin
          fetch_addr_d = branch ? branchTarget : redirect_addr_q;
          state_d      = ST_FETCH;
        end else if (branch) begin
          redirect_addr_d = branchTarget;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs come only from registers or the state register.
  always_comb begin
    imemReq     = (state_q == ST_FETCH) || (state_q == ST_DISCARD);
    instrValid  = (state_q == ST_HOLD);
    imemAddr    = fetch_addr_q;
    instruction = instr_q;
    pc          = pc_q;
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - randomized self-checking bench for instruction_fetch
module tb_instruction_fetch;
  import fetch_pkg::*;

  localparam int AW = 16;

  logic          clock = 1'b0;
  logic          resetN = 1'b0;
  logic          imemReq;
  logic [AW-1:0] imemAddr;
  logic          imemAck = 1'b0;
  logic [31:0]   imemData = 32'h0;
  logic          branch = 1'b0;
  logic [AW-1:0] branchTarget = '0;
  logic          stall = 1'b0;
  logic [31:0]   instruction;
  logic          instrValid;
  logic [AW-1:0] pc;

  instruction_fetch dut (
    .clock        (clock),
    .resetN       (resetN),
    .imemReq      (imemReq),
    .imemAddr     (imemAddr),
    .imemAck      (imemAck),
    .imemData     (imemData),
    .branch       (branch),
    .branchTarget (branchTarget),
    .stall        (stall),
    .instruction  (instruction),
    .instrValid   (instrValid),
    .pc           (pc)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return {a ^ 16'hA5C3, a};
  endfunction

  // Reference model: the stage is either talking to memory or not; when it
  // is, the outstanding fetch is either on the correct path or a wrong path
  // whose target is remembered.
  bit            m_busy;
  bit            m_valid;
  bit            m_wrong_path;
  logic [AW-1:0] m_next_addr;
  logic [AW-1:0] m_pending_target;
  logic [AW-1:0] m_pc;
  logic [31:0]   m_instr;

  task automatic model_reset();
    m_busy           = 1'b0;
    m_valid          = 1'b0;
    m_wrong_path     = 1'b0;
    m_next_addr      = '0;
    m_pending_target = '0;
    m_pc             = '0;
    m_instr          = NOP_INSTR;
  endtask

  task automatic model_step(input bit ack, input logic [31:0] data, input bit br,
                            input logic [AW-1:0] tgt, input bit stl);
    if (!m_busy) begin
      if (br) begin
        m_next_addr = tgt;
        m_valid     = 1'b0;
        m_busy      = 1'b1;
      end else if (!m_valid || !stl) begin
        m_valid = 1'b0;
        m_busy  = 1'b1;
      end
    end else if (!m_wrong_path) begin
      if (ack && br) begin
        m_next_addr = tgt;
      end else if (ack) begin
        m_instr     = data;
        m_pc        = m_next_addr;
        m_next_addr = AW'((int'(m_next_addr) + 1) % 65536);
        m_busy      = 1'b0;
        m_valid     = 1'b1;
      end else if (br) begin
        m_pending_target = tgt;
        m_wrong_path     = 1'b1;
      end
    end else begin
      if (ack) begin
        m_next_addr  = br ? tgt : m_pending_target;
        m_wrong_path = 1'b0;
      end else if (br) begin
        m_pending_target = tgt;
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("imemReq",     32'(imemReq),    32'(m_busy));
    check_eq("imemAddr",    32'(imemAddr),   32'(m_next_addr));
    check_eq("instrValid",  32'(instrValid), 32'(m_valid));
    check_eq("pc",          32'(pc),         32'(m_pc));
    check_eq("instruction", instruction,     m_instr);
  endtask

  function automatic logic [AW-1:0] pick_target();
    int r;
    r = int'($urandom_range(0, 3));
    if (r == 0) return AW'(16'hFFFF - 16'($urandom_range(0, 2)));
    if (r == 1) return AW'($urandom_range(0, 15));
    return AW'($urandom);
  endfunction

  int lat_left;
  int max_wait;
  int resets_done;

  initial begin
    model_reset();
    lat_left    = 0;
    resets_done = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_outputs();
    resetN = 1'b1;

    for (int cyc = 0; cyc < 5000; cyc++) begin
      max_wait = (cyc < 300) ? 0 : ((cyc < 2500) ? 3 : 5);

      // Asynchronous reset pulse while a wrong-path fetch is outstanding.
      if (m_busy && m_wrong_path && resets_done < 4 && $urandom_range(0, 3) == 0) begin
        resetN = 1'b0;
        #1;
        check_eq("rst_imemReq",    32'(imemReq),    32'd0);
        check_eq("rst_instrValid", 32'(instrValid), 32'd0);
        check_eq("rst_pc",         32'(pc),         32'd0);
        check_eq("rst_imemAddr",   32'(imemAddr),   32'd0);
        check_eq("rst_instr",      instruction,     NOP_INSTR);
        #1;
        resetN = 1'b1;
        model_reset();
        lat_left = 0;
        resets_done++;
      end

      imemAck      = imemReq && (lat_left == 0);
      imemData     = imemAck ? mem_word(imemAddr) : $urandom;
      branch       = (cyc >= 100) && ($urandom_range(0, 7) == 0);
      branchTarget = branch ? pick_target() : AW'($urandom);
      stall        = (cyc >= 200) && ($urandom_range(0, 2) == 0);

      model_step(imemAck, imemData, branch, branchTarget, stall);

      if (imemReq) begin
        if (imemAck) lat_left = int'($urandom_range(0, max_wait));
        else         lat_left--;
      end

      @(posedge clock);
      @(negedge clock);
      check_outputs();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
